alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Initiator side of the ALU operand/result interface. Accepts one operation at a time from the control path over a valid/ready request handshake, then drives A, B and opcode to the combinational ALU and holds them stable. It waits the per-opcode settle latency, captures the 64-bit C result into internal Z registers, and returns it over a valid/ready response handshake. Sits between the control unit and the ALU, replacing direct wiring so that mul/div can be multi-cycle.

Parameters:
wordSize, 32, operand width; result is 2*wordSize.
SIMPLE_LAT, 1, cycles from accept to capture for all non-mul/div opcodes (min 1).
MULDIV_LAT, 4, cycles from accept to capture for mul (5'b00011) and div (5'b00100) (min 1).

Ports:
clk  in  1  clock
clr  in  1  reset; one clock; reset is synchronous and active-high
req_valid  in  1  request present
req_ready  out  1  sequencer can accept
req_opcode  in  5  ALU opcode (nop=0, add=1 … not=15)
req_a  in  wordSize  operand A
req_b  in  wordSize  operand B
alu_a  out  wordSize  to ALU A
alu_b  out  wordSize  to ALU B
alu_opcode  out  5  to ALU opcode
alu_c  in  2*wordSize  ALU result C
rsp_valid  out  1  result available
rsp_ready  in  1  consumer takes result
rsp_lo  out  wordSize  captured C[wordSize-1:0]
rsp_hi  out  wordSize  captured C[2*wordSize-1:wordSize]
rsp_hi_we  out  1  HI register write enable (1 for mul/div only)
rsp_err  out  1  error flag (see Optional Feature)
busy  out  1  state != IDLE

Behaviour:
- Reset (clr high at a clk edge): state=IDLE; req_ready=1 on the following cycle. alu_a=alu_b=0, alu_opcode=0 (nop). rsp_valid=0, rsp_lo=rsp_hi=0, rsp_hi_we=0, rsp_err=0, counter=0. Reset mid-operation aborts the operation silently; no response is produced.
- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready at edge k: register req_a/req_b/req_opcode onto alu_*. Load counter with L-1, where L=MULDIV_LAT for opcode 3/4 and SIMPLE_LAT otherwise. Go to WAIT.
- WAIT: alu_* held constant. Counter decrements each cycle. When counter==0 at edge k+L: capture alu_c into rsp_lo/rsp_hi, set rsp_hi_we per opcode, assert rsp_valid, go to RESP. Total latency is L cycles from accept to rsp_valid.
- RESP: rsp_valid=1 and all rsp_* held stable until rsp_ready. On rsp_valid&&rsp_ready: deassert rsp_valid, return to IDLE. req_ready is 1 from the next cycle; there is no same-cycle re-accept.
- req_ready=0 in WAIT and RESP. req_valid while busy is ignored; the requester must hold it.
- rsp_ready asserted before rsp_valid has no effect.
- nop (opcode 0) follows the normal path with SIMPLE_LAT. Opcodes 16-31 are passed to the ALU unchanged with SIMPLE_LAT and rsp_hi_we=0.
- rsp_hi_we is forced 0 for all non-mul/div opcodes, regardless of C[63:32].
- alu_* keep their last values after completion; they are not cleared.

Optional Feature:
Macro ALU_SEQ_DIV0_EN.
- Defined: a div request with req_b==0 does not wait MULDIV_LAT. It goes to RESP after exactly 1 cycle with rsp_lo=0, rsp_hi=0, rsp_hi_we=0, rsp_err=1. alu_* are still loaded as normal. rsp_err=0 for all other responses.
- Not defined: rsp_err is tied 0 and div-by-zero follows the normal path, returning whatever alu_c holds.

Decomposition:
- Shared package alu_pkg: opcode localparams (nop … log_not), the opcode width (5), and an is_muldiv(opcode) function. The package is shared with the ALU and the control unit.
- One sub-module: alu_lat_counter. It takes a load, a load value and an enable, and outputs a zero flag; it is sized with $clog2(max(SIMPLE_LAT,MULDIV_LAT)+1).
- State encoding is local to this module.

Test Plan:
- add A=5, B=7, rsp_ready=1 → alu_* set 1 cycle after accept; rsp_valid after 1 cycle with rsp_lo=12, rsp_hi_we=0; req_ready back 1 cycle later.
- mul A=0x10000, B=0x10000, MULDIV_LAT=4 → rsp_valid exactly 4 cycles after accept; rsp_hi=1, rsp_lo=0, rsp_hi_we=1.
- Backpressure: and A=0xF0, B=0x3C with rsp_ready=0 for 5 cycles → rsp_lo=0x30 held stable, req_ready=0 throughout, and a second req_valid is not accepted until after rsp_ready.
- Reset mid-WAIT: div accepted, clr pulsed 2 cycles later → next cycle IDLE, rsp_valid never asserts, alu_opcode=0.
- ALU_SEQ_DIV0_EN: div A=9, B=0 → rsp_valid 1 cycle after accept, rsp_err=1, rsp_lo=rsp_hi=0. Without the macro, the same stimulus gives rsp_err=0 after 4 cycles.
- Back-to-back: sub 10-3 then shl 1<<4 with rsp_ready=1 → results 7 and 16, in order, with no lost or duplicated response.

Source files
------------

// File: rtl/alu_pkg.sv
// Opcode encodings and helpers shared by the ALU, the control unit and alu_op_sequencer.
package alu_pkg;

    localparam int unsigned OPC_W = 5;

    localparam logic [OPC_W-1:0] OP_NOP     = 5'd0;
    localparam logic [OPC_W-1:0] OP_ADD     = 5'd1;
    localparam logic [OPC_W-1:0] OP_SUB     = 5'd2;
    localparam logic [OPC_W-1:0] OP_MUL     = 5'd3;
    localparam logic [OPC_W-1:0] OP_DIV     = 5'd4;
    localparam logic [OPC_W-1:0] OP_AND     = 5'd5;
    localparam logic [OPC_W-1:0] OP_OR      = 5'd6;
    localparam logic [OPC_W-1:0] OP_XOR     = 5'd7;
    localparam logic [OPC_W-1:0] OP_SHL     = 5'd8;
    localparam logic [OPC_W-1:0] OP_SHR     = 5'd9;
    localparam logic [OPC_W-1:0] OP_SRA     = 5'd10;
    localparam logic [OPC_W-1:0] OP_ROL     = 5'd11;
    localparam logic [OPC_W-1:0] OP_ROR     = 5'd12;
    localparam logic [OPC_W-1:0] OP_NEG     = 5'd13;
    localparam logic [OPC_W-1:0] OP_NOR     = 5'd14;
    localparam logic [OPC_W-1:0] OP_LOG_NOT = 5'd15;

    function automatic logic is_muldiv(input logic [OPC_W-1:0] opcode);
        return (opcode == OP_MUL) || (opcode == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_lat_counter.sv
// Down-counter timing the ALU settle latency; zero flags that the result may be captured.
module alu_lat_counter #(
    parameter int unsigned SIMPLE_LAT = 1,
    parameter int unsigned MULDIV_LAT = 4,
    localparam int unsigned MAX_LAT   = (SIMPLE_LAT > MULDIV_LAT) ? SIMPLE_LAT : MULDIV_LAT,
    localparam int unsigned CNT_W     = $clog2(MAX_LAT + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Drives one operation at a time into the combinational ALU and returns the settled result.
// Optional: define ALU_SEQ_DIV0_EN to short-circuit divide-by-zero with rsp_err=1.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned wordSize   = 32,
    parameter int unsigned SIMPLE_LAT = 1,
    parameter int unsigned MULDIV_LAT = 4
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [OPC_W-1:0]      req_opcode,
    input  logic [wordSize-1:0]   req_a,
    input  logic [wordSize-1:0]   req_b,
    output logic [wordSize-1:0]   alu_a,
    output logic [wordSize-1:0]   alu_b,
    output logic [OPC_W-1:0]      alu_opcode,
    input  logic [2*wordSize-1:0] alu_c,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [wordSize-1:0]   rsp_lo,
    output logic [wordSize-1:0]   rsp_hi,
    output logic                  rsp_hi_we,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam int unsigned MAX_LAT = (SIMPLE_LAT > MULDIV_LAT) ? SIMPLE_LAT : MULDIV_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [CNT_W-1:0] SIMPLE_LOAD = CNT_W'(SIMPLE_LAT - 1);
    localparam logic [CNT_W-1:0] MULDIV_LOAD = CNT_W'(MULDIV_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e               state_q, state_d;
    logic [wordSize-1:0]  alu_a_q, alu_a_d;
    logic [wordSize-1:0]  alu_b_q, alu_b_d;
    logic [OPC_W-1:0]     alu_op_q, alu_op_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [wordSize-1:0]  rsp_lo_q, rsp_lo_d;
    logic [wordSize-1:0]  rsp_hi_q, rsp_hi_d;
    logic                 rsp_hi_we_q, rsp_hi_we_d;
`ifdef ALU_SEQ_DIV0_EN
    logic                 rsp_err_q, rsp_err_d;
    logic                 div0_q, div0_d;
    logic                 req_div0;
`endif

    logic                 accept;
    logic                 cnt_load;
    logic [CNT_W-1:0]     cnt_load_val;
    logic                 cnt_en;
    logic                 cnt_zero;

    assign accept = req_valid && (state_q == S_IDLE);

`ifdef ALU_SEQ_DIV0_EN
    assign req_div0 = (req_opcode == OP_DIV) && (req_b == '0);
`endif

    always_comb begin
        cnt_load_val = is_muldiv(req_opcode) ? MULDIV_LOAD : SIMPLE_LOAD;
`ifdef ALU_SEQ_DIV0_EN
        // Divide-by-zero completes on the first WAIT cycle.
        if (req_div0) begin
            cnt_load_val = '0;
        end
`endif
    end

    assign cnt_load = accept;
    assign cnt_en   = (state_q == S_WAIT);

    alu_lat_counter #(
        .SIMPLE_LAT (SIMPLE_LAT),
        .MULDIV_LAT (MULDIV_LAT)
    ) u_lat_counter (
        .clk      (clk),
        .clr      (clr),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        rsp_valid_d = rsp_valid_q;
        rsp_lo_d    = rsp_lo_q;
        rsp_hi_d    = rsp_hi_q;
        rsp_hi_we_d = rsp_hi_we_q;
`ifdef ALU_SEQ_DIV0_EN
        rsp_err_d   = rsp_err_q;
        div0_d      = div0_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    alu_a_d  = req_a;
                    alu_b_d  = req_b;
                    alu_op_d = req_opcode;
`ifdef ALU_SEQ_DIV0_EN
                    div0_d   = req_div0;
`endif
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_zero) begin
                    rsp_lo_d    = alu_c[wordSize-1:0];
                    rsp_hi_d    = alu_c[2*wordSize-1:wordSize];
                    rsp_hi_we_d = is_muldiv(alu_op_q);
`ifdef ALU_SEQ_DIV0_EN
                    rsp_err_d   = div0_q;
                    if (div0_q) begin
                        rsp_lo_d    = '0;
                        rsp_hi_d    = '0;
                        rsp_hi_we_d = 1'b0;
                    end
`endif
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= S_IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= OP_NOP;
            rsp_valid_q <= 1'b0;
            rsp_lo_q    <= '0;
            rsp_hi_q    <= '0;
            rsp_hi_we_q <= 1'b0;
`ifdef ALU_SEQ_DIV0_EN
            rsp_err_q   <= 1'b0;
            div0_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_lo_q    <= rsp_lo_d;
            rsp_hi_q    <= rsp_hi_d;
            rsp_hi_we_q <= rsp_hi_we_d;
`ifdef ALU_SEQ_DIV0_EN
            rsp_err_q   <= rsp_err_d;
            div0_q      <= div0_d;
`endif
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_lo     = rsp_lo_q;
    assign rsp_hi     = rsp_hi_q;
    assign rsp_hi_we  = rsp_hi_we_q;
`ifdef ALU_SEQ_DIV0_EN
    assign rsp_err    = rsp_err_q;
`else
    assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU driving alu_c.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    logic        clk;
    logic        clr;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_opcode;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_opcode;
    logic [63:0] alu_c;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_lo;
    logic [31:0] rsp_hi;
    logic        rsp_hi_we;
    logic        rsp_err;
    logic        busy;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    alu_op_sequencer #(
        .wordSize   (32),
        .SIMPLE_LAT (1),
        .MULDIV_LAT (4)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_c      (alu_c),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_lo     (rsp_lo),
        .rsp_hi     (rsp_hi),
        .rsp_hi_we  (rsp_hi_we),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; div-by-zero and unlisted opcodes return recognisable patterns.
    always_comb begin
        alu_c = 64'h0;
        case (alu_opcode)
            OP_ADD: alu_c = {32'h0000_0001, alu_a + alu_b};
            OP_SUB: alu_c = {32'h0, alu_a - alu_b};
            OP_MUL: alu_c = {32'h0, alu_a} * {32'h0, alu_b};
            OP_DIV: alu_c = (alu_b != 32'h0) ? {alu_a % alu_b, alu_a / alu_b}
                                               : {32'hBAD0_0001, 32'hBAD0_0000};
            OP_AND: alu_c = {32'h0, alu_a & alu_b};
            OP_SHL: alu_c = {32'h0, alu_a << alu_b[4:0]};
            default: alu_c = {32'hFFFF_FFFF, 27'h0, alu_opcode};
        endcase
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        req_opcode = op;
        req_a      = a;
        req_b      = b;
        req_valid  = 1'b1;
        check("issue_req_ready", req_ready, 1);
        tick();
        req_valid  = 1'b0;
    endtask

    task automatic wait_rsp(input int unsigned max_cyc, output int unsigned cyc);
        cyc = 0;
        while (!rsp_valid && cyc < max_cyc) begin
            tick();
            cyc++;
        end
        if (!rsp_valid) check("rsp_timeout", 0, 1);
    endtask

    int unsigned lat;
    int unsigned budget;
    logic        seen_valid;
    logic        hs_req, hs_rsp;
    int unsigned req_idx;
    logic [31:0] got[$];

    initial begin
        clr        = 1'b1;
        req_valid  = 1'b0;
        req_opcode = '0;
        req_a      = '0;
        req_b      = '0;
        rsp_ready  = 1'b0;
        tick();
        tick();
        clr = 1'b0;

        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_alu_op", alu_opcode, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_rsp_lo", rsp_lo, 0);
        check("rst_rsp_err", rsp_err, 0);

        // add 5+7 with rsp_ready already high
        rsp_ready = 1'b1;
        issue(OP_ADD, 32'd5, 32'd7);
        check("add_alu_a", alu_a, 5);
        check("add_alu_b", alu_b, 7);
        check("add_alu_op", alu_opcode, OP_ADD);
        check("add_busy", busy, 1);
        check("add_req_ready", req_ready, 0);
        wait_rsp(20, lat);
        check("add_lat", lat, 1);
        check("add_lo", rsp_lo, 12);
        check("add_hi_we", rsp_hi_we, 0);
        check("add_err", rsp_err, 0);
        tick();
        check("add_rsp_drop", rsp_valid, 0);
        check("add_req_ready_back", req_ready, 1);
        check("add_alu_held", alu_opcode, OP_ADD);

        // mul with MULDIV_LAT=4
        issue(OP_MUL, 32'h0001_0000, 32'h0001_0000);
        wait_rsp(20, lat);
        check("mul_lat", lat, 4);
        check("mul_hi", rsp_hi, 1);
        check("mul_lo", rsp_lo, 0);
        check("mul_hi_we", rsp_hi_we, 1);
        tick();

        // backpressure with a second request held during RESP
        rsp_ready = 1'b0;
        issue(OP_AND, 32'hF0, 32'h3C);
        wait_rsp(20, lat);
        check("and_lat", lat, 1);
        req_opcode = OP_ADD;
        req_a      = 32'd1;
        req_b      = 32'd1;
        req_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", rsp_valid, 1);
            check("bp_lo", rsp_lo, 32'h30);
            check("bp_req_ready", req_ready, 0);
            check("bp_alu_op", alu_opcode, OP_AND);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_rsp_drop", rsp_valid, 0);
        check("bp_req_ready_back", req_ready, 1);
        check("bp_no_early_accept", alu_opcode, OP_AND);
        tick();
        req_valid = 1'b0;
        check("bp_second_op", alu_opcode, OP_ADD);
        check("bp_second_a", alu_a, 1);
        wait_rsp(20, lat);
        check("bp_second_lo", rsp_lo, 2);
        tick();

        // opcode 20 is passed through with SIMPLE_LAT and no HI write
        issue(5'd20, 32'd3, 32'd4);
        check("op20_alu_op", alu_opcode, 20);
        wait_rsp(20, lat);
        check("op20_lat", lat, 1);
        check("op20_lo", rsp_lo, 20);
        check("op20_hi", rsp_hi, 32'hFFFF_FFFF);
        check("op20_hi_we", rsp_hi_we, 0);
        tick();

        // reset mid-WAIT
        issue(OP_DIV, 32'd100, 32'd5);
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("rstw_busy", busy, 0);
        check("rstw_req_ready", req_ready, 1);
        check("rstw_alu_op", alu_opcode, 0);
        seen_valid = rsp_valid;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen_valid = seen_valid | rsp_valid;
        end
        check("rstw_no_rsp", seen_valid, 0);

        // divide by zero
        issue(OP_DIV, 32'd9, 32'd0);
        check("div0_alu_op", alu_opcode, OP_DIV);
        check("div0_alu_a", alu_a, 9);
        wait_rsp(20, lat);
`ifdef ALU_SEQ_DIV0_EN
        check("div0_lat", lat, 1);
        check("div0_err", rsp_err, 1);
        check("div0_lo", rsp_lo, 0);
        check("div0_hi", rsp_hi, 0);
        check("div0_hi_we", rsp_hi_we, 0);
`else
        check("div0_lat", lat, 4);
        check("div0_err", rsp_err, 0);
        check("div0_lo", rsp_lo, 32'hBAD0_0000);
        check("div0_hi", rsp_hi, 32'hBAD0_0001);
        check("div0_hi_we", rsp_hi_we, 1);
`endif
        tick();

        // normal div clears any error flag
        issue(OP_DIV, 32'd17, 32'd5);
        wait_rsp(20, lat);
        check("div_lat", lat, 4);
        check("div_lo", rsp_lo, 3);
        check("div_hi", rsp_hi, 2);
        check("div_err", rsp_err, 0);
        tick();

        // back-to-back: sub 10-3 then shl 1<<4
        req_idx    = 0;
        req_opcode = OP_SUB;
        req_a      = 32'd10;
        req_b      = 32'd3;
        req_valid  = 1'b1;
        budget     = 0;
        while (budget < 30 && got.size() < 2) begin
            hs_req = req_valid && req_ready;
            hs_rsp = rsp_valid && rsp_ready;
            if (hs_rsp) got.push_back(rsp_lo);
            tick();
            budget++;
            if (hs_req) begin
                req_idx++;
                if (req_idx == 1) begin
                    req_opcode = OP_SHL;
                    req_a      = 32'd1;
                    req_b      = 32'd4;
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        check("b2b_count", got.size(), 2);
        check("b2b_first", (got.size() > 0) ? got[0] : 32'hDEAD, 7);
        check("b2b_second", (got.size() > 1) ? got[1] : 32'hDEAD, 16);
        for (int i = 0; i < 4; i++) tick();
        check("b2b_no_dup", rsp_valid, 0);
        check("b2b_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
